regfile_nr1w: RTL and testbench
===============================

// Module: regfile_nr1w
// PURPOSE
//  Parametrised register file: NUM_RD independent read ports, one write port, optional
//  hardwired-zero register, optional write-to-read bypass, optional registered read outputs.
//  Successor to the fixed 32:1 single-bit read mux; each read port is an internal DEPTH:1 mux
//  of WIDTH-bit words. Sits in the CPU datapath between decode (addresses) and the ALU.
// PARAMETERS
//  WIDTH     32  bits per register
//  ADDR_W    5   address bits; DEPTH = 2**ADDR_W registers
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: register 0 always reads 0 and ignores writes
//  BYPASS    1   1: a same-cycle write to the read address is forwarded to the read data
//  RD_REG    0   0: combinational read; 1: read data registered, 1-cycle latency
// PORTS
//  clk      in   1               rising-edge clock
//  rst_n    in   1               synchronous reset, active-low
//  wr_en    in   1               write enable
//  wr_addr  in   ADDR_W          write address
//  wr_data  in   WIDTH           write data
//  rd_addr  in   NUM_RD*ADDR_W   read addresses; port p = [p*ADDR_W +: ADDR_W]
//  rd_data  out  NUM_RD*WIDTH    read data; port p = [p*WIDTH +: WIDTH]
// BEHAVIOUR
//  - Reset: clk edge with rst_n=0 clears all DEPTH registers to 0 (and the RD_REG output regs);
//    rst_n=0 overrides wr_en in the same cycle (no write occurs).
//  - Write: on clk edge with rst_n=1 and wr_en=1, mem[wr_addr] <= wr_data. If ZERO_REG=1 and
//    wr_addr=0 the write is dropped. Exactly one write per cycle; no partial writes.
//  - Read word for port p in cycle t (before RD_REG stage):
//      ZERO_REG=1 && rd_addr_p==0                    -> 0
//      else BYPASS=1 && wr_en && wr_addr==rd_addr_p  -> wr_data (new value, same cycle)
//      else                                          -> mem[rd_addr_p]
//    Zero rule has priority over bypass. BYPASS=0: same-cycle read returns the old value;
//    new value is visible from cycle t+1.
//  - RD_REG=0: rd_data is combinational from rd_addr/wr_* and storage; after reset reads 0.
//  - RD_REG=1: read word sampled at clk edge; rd_data valid one cycle after rd_addr; reset 0.
//  - Ports are fully independent; any number may read the same address, including the write
//    address, simultaneously. All addresses are in range (DEPTH = 2**ADDR_W), no wrap logic.
//  - No X propagation: every register has a defined reset value; wr_data of X only corrupts
//    the addressed register.
// TESTING  (default parameters unless stated)
//  1 Reset: write 0xFFFFFFFF to r1..r31, pulse rst_n=0 one cycle -> all rd_data = 0 on every addr.
//  2 Sweep: write r[i]=0xA5A50000+i for i=1..31; port0 reads i, port1 reads 31-i -> both
//    return the written values; addr 0 returns 0 on both ports.
//  3 Zero reg: wr_en=1, wr_addr=0, wr_data=0xDEADBEEF -> rd_data for addr 0 stays 0 next cycle.
//  4 Bypass: r5=0x11; same cycle wr r5=0x22 with rd_addr0=5 -> BYPASS=1: 0x22 same cycle;
//    BYPASS=0: 0x11 same cycle, 0x22 next cycle.
//  5 Reset vs write: rst_n=0 and wr_en=1 to r7=0x77 same edge -> r7 reads 0 afterwards.
//  6 RD_REG=1, NUM_RD=3: addresses 3,3,4 with r3=0x3, r4=0x4 -> rd_data {0x4,0x3,0x3} exactly
//    one clk later; unchanged in the presentation cycle.

Source files
------------

// File: rtl/regfile_nr1w.sv
// regfile_nr1w: parametrised register file with NUM_RD read ports and one write port,
// optional hardwired zero register, write-to-read bypass and registered read outputs.
module regfile_nr1w #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_REG   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [WIDTH-1:0]        mem [DEPTH];
    logic [NUM_RD*WIDTH-1:0] rd_word;
    always_ff @(posedge clk)
        if (!rst_n)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (wr_en && !(ZERO_REG != 0 && wr_addr == '0))
            mem[wr_addr] <= wr_data;
    genvar p;
    for (p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[p*ADDR_W +: ADDR_W];
        // zero register wins over bypass so r0 never leaks a dropped write
        assign rd_word[p*WIDTH +: WIDTH] = (ZERO_REG != 0 && a == '0) ? '0 :
                                           (BYPASS != 0 && wr_en && wr_addr == a) ? wr_data :
                                           mem[a];
    end
    if (RD_REG != 0) begin : g_reg
        always_ff @(posedge clk)
            rd_data <= rst_n ? rd_word : '0;
    end else begin : g_comb
        assign rd_data = rd_word;
    end
endmodule

// File: tb/tb_regfile_nr1w.sv
// tb_regfile_nr1w: checks three configurations (default, no bypass, registered 3-port)
// against an array-based model of the register file.
module tb_regfile_nr1w;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        wr_en = 0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [9:0]  ra01 = '0;
    logic [14:0] ra2 = '0;
    logic [63:0] rd0, rd1;
    logic [95:0] rd2;
    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_mem [32];
    logic [31:0] exp2 [3];

    always #5 clk = ~clk;

    regfile_nr1w u0 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
                     .wr_data(wr_data), .rd_addr(ra01), .rd_data(rd0));
    regfile_nr1w #(.BYPASS(0)) u1 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
                     .wr_data(wr_data), .rd_addr(ra01), .rd_data(rd1));
    regfile_nr1w #(.NUM_RD(3), .RD_REG(1)) u2 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en),
                     .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(ra2), .rd_data(rd2));

    function automatic logic [31:0] exp_word(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return ref_mem[a];
    endfunction

    task automatic tick();
        logic [31:0] nxt [3];
        for (int p = 0; p < 3; p++) nxt[p] = rst_n ? exp_word(ra2[p*5 +: 5], 1'b1) : 32'd0;
        @(posedge clk);
        exp2 = nxt;
        if (!rst_n) for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        else if (wr_en && wr_addr != 5'd0) ref_mem[wr_addr] = wr_data;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic test_reset();
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hFFFF_FFFF);
        rst_n = 0; tick(); rst_n = 1;
        for (int i = 0; i < 32; i++) begin
            ra01 = {5'(31 - i), 5'(i)};
            ra2 = {3{5'(i)}};
            #1;
            total++; if (rd0 !== 64'd0) begin bad++; $display("FAIL reset_u0 addr=%0d got=%h exp=0", i, rd0); end
            total++; if (rd1 !== 64'd0) begin bad++; $display("FAIL reset_u1 addr=%0d got=%h exp=0", i, rd1); end
            tick();
            total++; if (rd2 !== 96'd0) begin bad++; $display("FAIL reset_u2 addr=%0d got=%h exp=0", i, rd2); end
        end
    endtask

    task automatic test_sweep();
        logic [31:0] e0, e1;
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            ra01 = {5'(31 - i), 5'(i)};
            #1;
            e0 = (i == 0) ? 32'd0 : 32'hA5A5_0000 + 32'(i);
            e1 = (i == 31) ? 32'd0 : 32'hA5A5_0000 + 32'(31 - i);
            total++; if (rd0 !== {e1, e0}) begin bad++; $display("FAIL sweep_u0 i=%0d got=%h exp=%h", i, rd0, {e1, e0}); end
            total++; if (rd1 !== {e1, e0}) begin bad++; $display("FAIL sweep_u1 i=%0d got=%h exp=%h", i, rd1, {e1, e0}); end
            tick();
        end
    endtask

    task automatic test_zero();
        wr_en = 1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF; ra01 = '0;
        #1;
        total++; if (rd0 !== 64'd0) begin bad++; $display("FAIL zero_same got=%h exp=0", rd0); end
        tick(); wr_en = 0;
        #1;
        total++; if (rd0 !== 64'd0) begin bad++; $display("FAIL zero_next_u0 got=%h exp=0", rd0); end
        total++; if (rd1 !== 64'd0) begin bad++; $display("FAIL zero_next_u1 got=%h exp=0", rd1); end
    endtask

    task automatic test_bypass();
        wr(5'd5, 32'h11);
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'h22; ra01 = {5'd5, 5'd5};
        #1;
        total++; if (rd0 !== {32'h22, 32'h22}) begin bad++; $display("FAIL bypass_on got=%h exp=%h", rd0, {32'h22, 32'h22}); end
        total++; if (rd1 !== {32'h11, 32'h11}) begin bad++; $display("FAIL bypass_off_same got=%h exp=%h", rd1, {32'h11, 32'h11}); end
        tick(); wr_en = 0;
        #1;
        total++; if (rd1 !== {32'h22, 32'h22}) begin bad++; $display("FAIL bypass_off_next got=%h exp=%h", rd1, {32'h22, 32'h22}); end
        total++; if (rd0 !== {32'h22, 32'h22}) begin bad++; $display("FAIL bypass_on_next got=%h exp=%h", rd0, {32'h22, 32'h22}); end
    endtask

    task automatic test_rst_vs_write();
        wr(5'd7, 32'h70);
        rst_n = 0; wr_en = 1; wr_addr = 5'd7; wr_data = 32'h77;
        tick();
        rst_n = 1; wr_en = 0; ra01 = {5'd7, 5'd7};
        #1;
        total++; if (rd0 !== 64'd0) begin bad++; $display("FAIL rst_vs_wr_u0 got=%h exp=0", rd0); end
        total++; if (rd1 !== 64'd0) begin bad++; $display("FAIL rst_vs_wr_u1 got=%h exp=0", rd1); end
    endtask

    task automatic test_rdreg();
        ra2 = '0;
        wr(5'd3, 32'h3);
        wr(5'd4, 32'h4);
        ra2 = {5'd4, 5'd3, 5'd3};
        #1;
        total++; if (rd2 !== {exp2[2], exp2[1], exp2[0]}) begin bad++; $display("FAIL rdreg_hold got=%h exp=%h", rd2, {exp2[2], exp2[1], exp2[0]}); end
        tick();
        total++; if (rd2 !== {32'h4, 32'h3, 32'h3}) begin bad++; $display("FAIL rdreg_latency got=%h exp=%h", rd2, {32'h4, 32'h3, 32'h3}); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 31) != 0);
            wr_en = 1'($urandom);
            wr_addr = 5'($urandom);
            wr_data = $urandom;
            ra01 = 10'($urandom);
            ra2 = 15'($urandom);
            if ($urandom_range(0, 2) == 0) ra01[4:0] = wr_addr;
            if ($urandom_range(0, 2) == 0) ra2[9:5] = wr_addr;
            #1;
            for (int p = 0; p < 2; p++) begin
                e = exp_word(ra01[p*5 +: 5], 1'b1);
                total++; if (rd0[p*32 +: 32] !== e) begin bad++; $display("FAIL rand_u0 n=%0d p=%0d got=%h exp=%h", n, p, rd0[p*32 +: 32], e); end
                e = exp_word(ra01[p*5 +: 5], 1'b0);
                total++; if (rd1[p*32 +: 32] !== e) begin bad++; $display("FAIL rand_u1 n=%0d p=%0d got=%h exp=%h", n, p, rd1[p*32 +: 32], e); end
            end
            tick();
            for (int p = 0; p < 3; p++) begin
                total++; if (rd2[p*32 +: 32] !== exp2[p]) begin bad++; $display("FAIL rand_u2 n=%0d p=%0d got=%h exp=%h", n, p, rd2[p*32 +: 32], exp2[p]); end
            end
        end
        rst_n = 1; wr_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        rst_n = 0; tick(); rst_n = 1;
        test_reset();
        test_sweep();
        test_zero();
        test_bypass();
        test_rst_vs_write();
        test_rdreg();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
